// File: rtl/intersection_controller.sv
// Two-road intersection sequencer: road A green by default, latched side-road request runs one handover.
// Latency: lamps decode directly from the state register (no extra output stage).
// Backpressure: none; Req_B is latched in pend_B so short pulses are never lost.
module intersection_controller #(
  parameter int GREEN_A_MIN = 16,
  parameter int GREEN_B     = 8,
  parameter int YELLOW      = 4,
  parameter int ALL_RED     = 2,
  parameter int TIMER_W     = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Set,
  input  logic       Req_B,
  output logic       Red_A,
  output logic       Yellow_A,
  output logic       Green_A,
  output logic       Red_B,
  output logic       Yellow_B,
  output logic       Green_B,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLR_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLR_BA   = 3'd5,
    HOLD     = 3'd6,
    ILLEGAL  = 3'd7
  } state_t;

  // Timer reload values: a state lasts exactly its duration when loaded with duration-1.
  localparam logic [TIMER_W-1:0] T_GA = TIMER_W'(GREEN_A_MIN - 1);
  localparam logic [TIMER_W-1:0] T_GB = TIMER_W'(GREEN_B - 1);
  localparam logic [TIMER_W-1:0] T_Y  = TIMER_W'(YELLOW - 1);
  localparam logic [TIMER_W-1:0] T_R  = TIMER_W'(ALL_RED - 1);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pend_q, pend_d;
  logic               pend_eff;
  logic               timer_zero;

  assign timer_zero = (timer_q == '0);
  // A request arriving in the very cycle A's minimum expires is honoured immediately.
  assign pend_eff   = pend_q | Req_B;

  // Next-state, timer and request-latch logic; Set overrides normal sequencing.
  always_comb begin
    state_d = state_q;
    timer_d = timer_zero ? '0 : timer_q - TIMER_W'(1);
    pend_d  = pend_eff;
    if (Set) begin
      state_d = HOLD;
      timer_d = T_GA;
    end else begin
      case (state_q)
        A_GREEN: begin
          if (timer_zero && pend_eff) begin
            state_d = A_YELLOW;
            timer_d = T_Y;
          end
        end
        A_YELLOW: begin
          if (timer_zero) begin
            state_d = CLR_AB;
            timer_d = T_R;
          end
        end
        CLR_AB: begin
          if (timer_zero) begin
            state_d = B_GREEN;
            timer_d = T_GB;
            // Entering B green serves the request; a coincident Req_B is absorbed.
            pend_d  = 1'b0;
          end
        end
        B_GREEN: begin
          if (timer_zero) begin
            state_d = B_YELLOW;
            timer_d = T_Y;
          end
        end
        B_YELLOW: begin
          if (timer_zero) begin
            state_d = CLR_BA;
            timer_d = T_R;
          end
        end
        CLR_BA: begin
          if (timer_zero) begin
            state_d = A_GREEN;
            timer_d = T_GA;
          end
        end
        HOLD: begin
          state_d = A_GREEN;
          timer_d = T_GA;
        end
        default: begin
          state_d = HOLD;
          timer_d = T_GA;
        end
      endcase
    end
  end

  // State, timer and request registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= A_GREEN;
      timer_q <= T_GA;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  // Lamp decode: exactly one lamp per road in every state, red for all-red and hold states.
  always_comb begin
    Red_A    = 1'b1;
    Yellow_A = 1'b0;
    Green_A  = 1'b0;
    Red_B    = 1'b1;
    Yellow_B = 1'b0;
    Green_B  = 1'b0;
    case (state_q)
      A_GREEN: begin
        Red_A   = 1'b0;
        Green_A = 1'b1;
      end
      A_YELLOW: begin
        Red_A    = 1'b0;
        Yellow_A = 1'b1;
      end
      B_GREEN: begin
        Red_B   = 1'b0;
        Green_B = 1'b1;
      end
      B_YELLOW: begin
        Red_B    = 1'b0;
        Yellow_B = 1'b1;
      end
      default: begin
        Red_A = 1'b1;
        Red_B = 1'b1;
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: expected per-cycle states queued from the timing plan.
// Latency: outputs compared at the falling edge of each cycle.
// Backpressure: not applicable.
module tb_intersection_controller;

  localparam logic [2:0] AG  = 3'd0;
  localparam logic [2:0] AY  = 3'd1;
  localparam logic [2:0] CAB = 3'd2;
  localparam logic [2:0] BG  = 3'd3;
  localparam logic [2:0] BY  = 3'd4;
  localparam logic [2:0] CBA = 3'd5;
  localparam logic [2:0] HLD = 3'd6;

  logic       CLK = 1'b0;
  logic       Reset, Set, Req_B;
  logic       ra, ya, ga, rb, yb, gb;
  logic [2:0] st;
  logic       ra2, ya2, ga2, rb2, yb2, gb2;
  logic [2:0] st2;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp2_q[$];

  always #5 CLK = ~CLK;

  intersection_controller dut (
    .CLK(CLK), .Reset(Reset), .Set(Set), .Req_B(Req_B),
    .Red_A(ra), .Yellow_A(ya), .Green_A(ga),
    .Red_B(rb), .Yellow_B(yb), .Green_B(gb),
    .State(st)
  );

  intersection_controller #(.GREEN_A_MIN(16), .GREEN_B(1), .YELLOW(1), .ALL_RED(1), .TIMER_W(8)) dut_min (
    .CLK(CLK), .Reset(Reset), .Set(Set), .Req_B(Req_B),
    .Red_A(ra2), .Yellow_A(ya2), .Green_A(ga2),
    .Red_B(rb2), .Yellow_B(yb2), .Green_B(gb2),
    .State(st2)
  );

  // Lamp pattern {Red_A,Yellow_A,Green_A,Red_B,Yellow_B,Green_B} for each state.
  function automatic logic [5:0] lamps_for(input logic [2:0] s);
    case (s)
      AG:      return 6'b001_100;
      AY:      return 6'b010_100;
      BG:      return 6'b100_001;
      BY:      return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Scoreboard: pop one expected state per cycle and compare state code and lamps.
  always @(negedge CLK) begin
    logic [2:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("d1_state", {5'd0, st}, {5'd0, e});
      check_eq("d1_lamps", {2'd0, ra, ya, ga, rb, yb, gb}, {2'd0, lamps_for(e)});
    end
    if (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      check_eq("d2_state", {5'd0, st2}, {5'd0, e});
      check_eq("d2_lamps", {2'd0, ra2, ya2, ga2, rb2, yb2, gb2}, {2'd0, lamps_for(e)});
    end
    if (!Reset) begin
      check_eq("green_excl", {7'd0, ga & gb}, 8'd0);
      check_eq("green_excl_min", {7'd0, ga2 & gb2}, 8'd0);
    end
  end

  task automatic seg(input int which, input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 1) exp_q.push_back(s);
      else            exp2_q.push_back(s);
    end
  endtask

  // Drive inputs for one cycle, then move just past the closing edge.
  task automatic cyc(input logic req, input logic set, input logic rst);
    Req_B = req;
    Set   = set;
    Reset = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic rst2();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    Set   = 1'b0;
    Req_B = 1'b0;

    // Idle after reset: A stays green.
    rst2();
    seg(1, AG, 100);
    repeat (100) cyc(1'b0, 1'b0, 1'b0);

    // Single early request.
    rst2();
    seg(1, AG, 16); seg(1, AY, 4); seg(1, CAB, 2); seg(1, BG, 8);
    seg(1, BY, 4); seg(1, CBA, 2); seg(1, AG, 20);
    for (int c = 0; c < 56; c++) cyc(c == 3, 1'b0, 1'b0);

    // Late request, then re-arm during B green.
    rst2();
    seg(1, AG, 41); seg(1, AY, 4); seg(1, CAB, 2); seg(1, BG, 8);
    seg(1, BY, 4); seg(1, CBA, 2); seg(1, AG, 16); seg(1, AY, 4);
    seg(1, CAB, 2); seg(1, BG, 8); seg(1, BY, 4); seg(1, CBA, 2); seg(1, AG, 10);
    for (int c = 0; c < 107; c++) cyc((c == 40) || (c == 50), 1'b0, 1'b0);

    // Maintenance hold mid B green, then full A minimum after release.
    rst2();
    seg(1, AG, 16); seg(1, AY, 4); seg(1, CAB, 2); seg(1, BG, 4);
    seg(1, HLD, 5); seg(1, AG, 16); seg(1, AY, 4); seg(1, CAB, 2);
    seg(1, BG, 8); seg(1, BY, 4); seg(1, CBA, 2); seg(1, AG, 4);
    for (int c = 0; c < 71; c++) cyc((c == 0) || (c == 31), (c >= 25) && (c <= 29), 1'b0);

    // Set and Req_B together with Reset: reset wins, no pending request survives.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    seg(1, AG, 20);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);

    // Reset during A yellow clears the pending request.
    rst2();
    seg(1, AG, 16); seg(1, AY, 3); seg(1, AG, 40);
    for (int c = 0; c < 18; c++) cyc(c == 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (40) cyc(1'b0, 1'b0, 1'b0);

    // Single-cycle yellow, all-red and B green on the minimal instance.
    rst2();
    seg(2, AG, 16); seg(2, AY, 1); seg(2, CAB, 1); seg(2, BG, 1);
    seg(2, BY, 1); seg(2, CBA, 1); seg(2, AG, 10);
    for (int c = 0; c < 31; c++) cyc(c == 2, 1'b0, 1'b0);

    check_eq("queue_drained", 8'(exp_q.size() + exp2_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequencer for a two-road intersection: main road A and side road B, each with its own Red/Yellow/Green lamp triple. Main road A holds green by default; a latched side-road request on `Req_B` runs one full handover cycle with yellow and all-red clearance intervals, then returns to A. A maintenance `Set` input forces all-red hold. The block sits above the single-approach light logic and replaces free-running per-approach counters with one coordinated timer and FSM.

## Interface
- `GREEN_A_MIN`, 16: minimum A green duration, in cycles.
- `GREEN_B`, 8: B green duration, in cycles.
- `YELLOW`, 4: yellow duration for either road, in cycles.
- `ALL_RED`, 2: clearance interval after each yellow, in cycles.
- `TIMER_W`, 8: timer width. Every duration must lie in 1..2^TIMER_W−1.
- `CLK`  in  1  single clock, rising-edge.
- `Reset`  in  1  synchronous, active-high.
- `Set`  in  1  maintenance hold, level-sensitive.
- `Req_B`  in  1  side-road request; pulse or level, sampled each cycle.
- `Red_A`, `Yellow_A`, `Green_A`  out  1 each  road A lamps.
- `Red_B`, `Yellow_B`, `Green_B`  out  1 each  road B lamps.
- `State`  out  3  current FSM state code, for debug.

## Operation
- **States and codes:**
  - A_GREEN=0, A_YELLOW=1, CLR_AB=2, B_GREEN=3, B_YELLOW=4, CLR_BA=5, HOLD=6.
  - Code 7 is illegal; it goes to HOLD on the next cycle.
- **Lamp decode** (decoded from the state register):
  - Exactly one lamp per road is on in every state.
  - A_GREEN: Green_A, Red_B.
  - A_YELLOW: Yellow_A, Red_B.
  - B_GREEN: Red_A, Green_B.
  - B_YELLOW: Red_A, Yellow_B.
  - CLR_AB, CLR_BA, HOLD: Red_A, Red_B.
- **Timer:**
  - On entry to a state, the timer loads duration−1.
  - The timer decrements each cycle and saturates at 0.
  - A timed state exits on the cycle after the timer reads 0. It therefore lasts exactly its duration.
- **Transitions:**
  - A_GREEN→A_YELLOW when timer==0 and `pend_B`==1. Otherwise A_GREEN stays (timer held at 0).
  - A_YELLOW→CLR_AB→B_GREEN→B_YELLOW→CLR_BA→A_GREEN, each advancing on timer==0.
- **Request latch `pend_B`:**
  - Set by `Req_B`==1 in any cycle.
  - Cleared in the cycle the FSM enters B_GREEN. A `Req_B` in that same cycle is absorbed (clear wins).
  - A `Req_B` during B_GREEN, B_YELLOW or CLR_BA re-arms `pend_B`. A then serves its full `GREEN_A_MIN` before switching again.
- **Priority:** `Reset` > `Set` > normal sequencing.
- **HOLD:**
  - `Set`==1 forces HOLD on the next edge from any state. This includes mid-yellow and mid-green; no yellow is inserted.
  - The FSM stays in HOLD while `Set`==1. `pend_B` keeps latching during HOLD.
  - After `Set` falls, the FSM enters A_GREEN on the next edge with the full `GREEN_A_MIN` timer.
- **Reset (synchronous, any state):**
  - FSM=A_GREEN, timer=`GREEN_A_MIN`−1, `pend_B`=0.
  - Outputs: Green_A=1, Red_B=1, all other lamps 0, `State`=0.

## Timing
- Cycle 0 is the first cycle with `Reset`=0. State is A_GREEN in cycle 0.
- Lamp outputs change in the same cycle the state register changes. There is no extra output latency.
- Request-to-B_GREEN latency, request pending before A minimum expires: exactly `YELLOW`+`ALL_RED`+1 cycles after A_GREEN's timer first reads 0.
- Lamp-interval durations:
  - A green: `GREEN_A_MIN` cycles minimum.
  - B green: exactly `GREEN_B` cycles.
  - Yellow: exactly `YELLOW` cycles.
  - Each all-red clearance: exactly `ALL_RED` cycles.
- Green_A and Green_B are never both 1. A green never directly follows the other road's green or yellow.

## Test plan
- **Reset with no request:** hold `Reset` 2 cycles, then 100 cycles idle.
  - Green_A=1 and Red_B=1 throughout; `State`=0.
- **Single request, defaults:** `Req_B` pulse in cycle 3. Required sequence:
  - A_GREEN cycles 0–15.
  - A_YELLOW 16–19.
  - CLR_AB 20–21.
  - B_GREEN 22–29.
  - B_YELLOW 30–33.
  - CLR_BA 34–35.
  - A_GREEN from 36.
- **Late request and re-arm:** `Req_B` pulse in cycle 40. Second `Req_B` pulse during the resulting B_GREEN.
  - First pulse: A_YELLOW starts at cycle 41.
  - Second pulse: after the return to A_GREEN, A green lasts exactly 16 cycles, then a second handover runs.
- **Set mid-operation:** `Set`=1 for 5 cycles starting mid-B_GREEN.
  - Next cycle: HOLD with Red_A=Red_B=1.
  - After release: A_GREEN on the next edge with a full 16-cycle minimum.
  - `Set` asserted together with `Reset`: reset state results.
- **Reset mid-yellow:** `Reset` for 1 cycle during A_YELLOW.
  - A_GREEN next cycle; `pend_B`=0, so no handover without a new request.
- **Boundary parameters:** `YELLOW`=1, `ALL_RED`=1, `GREEN_B`=1.
  - Each of these states lasts exactly one cycle.
  - Lamp mutual-exclusion assertion holds every cycle.
